// File: rtl/sipo_layer.sv
// sipo_layer: serial-in parallel-out frame collector.
//   Collects a variable-length stream of signed words into one parallel frame
//   and presents it with its word count. Valid/ready handshake on both sides.
//
// Ports:
//   clk_i        clock, rising edge
//   reset_i      asynchronous active-high reset
//   valid_i      upstream word valid
//   ready_o      this block accepts a word
//   data_i       serial input word (signed)
//   data_size_i  frame length, sampled with the first word of a frame
//   valid_o      parallel frame valid
//   ready_i      downstream accepts the frame
//   data_o       parallel frame, word k at data_o[k] (signed)
//   data_size_o  word count of the frame on data_o
//
// Build option:
//   SIPO_DOUBLE_BUFFER_EN  separate fill and output buffers; filling continues
//                          while the output frame waits for its handshake.
//
// States:
//   eFILL  | collecting words, no frame on the output
//   eVALID | frame presented on the output
//   eFULL  | (double buffer) output waiting and fill buffer also complete
module sipo_layer #(
  parameter int MAX_OUTPUT_SIZE = 5,
  parameter int WORD_SIZE       = 16,
  localparam int SW             = $clog2(MAX_OUTPUT_SIZE + 1)
) (
  input  logic                                            clk_i,
  input  logic                                            reset_i,
  input  logic                                            valid_i,
  output logic                                            ready_o,
  input  logic signed [WORD_SIZE-1:0]                     data_i,
  input  logic        [SW-1:0]                            data_size_i,
  output logic                                            valid_o,
  input  logic                                            ready_i,
  output logic signed [MAX_OUTPUT_SIZE-1:0][WORD_SIZE-1:0] data_o,
  output logic        [SW-1:0]                            data_size_o
);

  typedef logic [MAX_OUTPUT_SIZE-1:0][WORD_SIZE-1:0] frame_t;

  typedef enum logic [1:0] {
    eFILL,
    eVALID
`ifdef SIPO_DOUBLE_BUFFER_EN
    , eFULL
`endif
  } state_t;

  state_t          state;
  logic [SW-1:0]   idx;
  logic [SW-1:0]   len_q;
  frame_t          fbuf;
  frame_t          fill_next;
  logic [SW-1:0]   eff_len;
  logic            consume;
  logic            produce;
  logic            first;
  logic            last;

`ifdef SIPO_DOUBLE_BUFFER_EN
  frame_t          obuf;
  logic [SW-1:0]   fill_size;
`endif

  // Zero or oversized lengths fall back to a full frame.
  function automatic logic [SW-1:0] clamp_len(input logic [SW-1:0] sz);
    if (sz == '0 || sz > SW'(MAX_OUTPUT_SIZE)) return SW'(MAX_OUTPUT_SIZE);
    return sz;
  endfunction

  // ready_o is forced low while reset is held so nothing is taken mid-reset.
`ifdef SIPO_DOUBLE_BUFFER_EN
  assign ready_o = !reset_i && (state == eFILL || state == eVALID);
  assign data_o  = obuf;
`else
  assign ready_o = !reset_i && (state == eFILL);
  assign data_o  = fbuf;
`endif
  assign valid_o = (state != eFILL);

  always_comb begin
    consume   = valid_i && ready_o;
    produce   = valid_o && ready_i;
    first     = (idx == '0);
    // The first word of a frame uses the live size; later words use the latch.
    eff_len   = first ? clamp_len(data_size_i) : len_q;
    last      = consume && (idx == eff_len - SW'(1));
    fill_next = fbuf;
    if (consume) begin
      if (first) fill_next = '0;
      fill_next[idx] = data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= eFILL;
      idx         <= '0;
      len_q       <= SW'(MAX_OUTPUT_SIZE);
      fbuf        <= '0;
      data_size_o <= SW'(MAX_OUTPUT_SIZE);
`ifdef SIPO_DOUBLE_BUFFER_EN
      obuf        <= '0;
      fill_size   <= SW'(MAX_OUTPUT_SIZE);
`endif
    end else begin
      fbuf <= fill_next;
      if (consume) begin
        if (first) len_q <= eff_len;
        idx <= last ? '0 : idx + SW'(1);
      end
`ifdef SIPO_DOUBLE_BUFFER_EN
      case (state)
        eFILL: begin
          if (last) begin
            obuf        <= fill_next;
            data_size_o <= eff_len;
            state       <= eVALID;
          end
        end
        eVALID: begin
          if (last) begin
            if (produce) begin
              // Back-to-back frame: swap in the new one with no bubble.
              obuf        <= fill_next;
              data_size_o <= eff_len;
            end else begin
              fill_size <= eff_len;
              state     <= eFULL;
            end
          end else if (produce) begin
            state <= eFILL;
          end
        end
        eFULL: begin
          if (produce) begin
            obuf        <= fbuf;
            data_size_o <= fill_size;
            state       <= eVALID;
          end
        end
        default: state <= eFILL;
      endcase
`else
      case (state)
        eFILL: begin
          if (last) begin
            data_size_o <= eff_len;
            state       <= eVALID;
          end
        end
        eVALID: begin
          if (produce) state <= eFILL;
        end
        default: state <= eFILL;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_sipo_layer.sv
// Directed testbench for sipo_layer with hand-computed expected frames.
module tb_sipo_layer;
  localparam int MAX = 5;
  localparam int W   = 16;
  localparam int SW  = 3;

  logic                         clk_i = 1'b0;
  logic                         reset_i = 1'b1;
  logic                         valid_i = 1'b0;
  logic                         ready_o;
  logic signed [W-1:0]          data_i = '0;
  logic        [SW-1:0]         data_size_i = '0;
  logic                         valid_o;
  logic                         ready_i = 1'b0;
  logic signed [MAX-1:0][W-1:0] data_o;
  logic        [SW-1:0]         data_size_o;

  int total = 0;
  int bad   = 0;

  sipo_layer #(.MAX_OUTPUT_SIZE(MAX), .WORD_SIZE(W)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .data_size_i (data_size_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .data_size_o (data_size_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] fr(input int w0, input int w1, input int w2,
                                     input int w3, input int w4);
    return {16'(w4), 16'(w3), 16'(w2), 16'(w1), 16'(w0)};
  endfunction

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1);
  end

  initial begin
    repeat (2) tick;
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_ready", ready_o, 1'b0);
    chk("rst_data", data_o, 80'd0);
    chk("rst_size", data_size_o, 3'd5);
    reset_i = 1'b0;
    #1;
    chk("rel_ready", ready_o, 1'b1);

`ifndef SIPO_DOUBLE_BUFFER_EN
    // len 3: 10, -2, 7
    tick;
    ready_i = 1'b1; valid_i = 1'b1; data_size_i = 3'd3;
    data_i = 16'sd10; tick;
    chk("t1_v_after1", valid_o, 1'b0);
    data_i = -16'sd2; tick;
    chk("t1_v_after2", valid_o, 1'b0);
    data_i = 16'sd7; tick;
    chk("t1_valid", valid_o, 1'b1);
    chk("t1_data", data_o, fr(10, -2, 7, 0, 0));
    chk("t1_size", data_size_o, 3'd3);
    chk("t1_ready", ready_o, 1'b0);
    valid_i = 1'b0; tick;
    chk("t1_v_drop", valid_o, 1'b0);
    chk("t1_r_back", ready_o, 1'b1);

    // len 5 with downstream stalled; input words offered during eVALID are ignored
    ready_i = 1'b0; valid_i = 1'b1; data_size_i = 3'd5;
    for (int i = 1; i <= 5; i++) begin
      data_i = 16'(i); tick;
    end
    data_i = 16'sd77;
    for (int k = 0; k < 4; k++) begin
      chk("t2_valid", valid_o, 1'b1);
      chk("t2_data", data_o, fr(1, 2, 3, 4, 5));
      chk("t2_ready", ready_o, 1'b0);
      if (k < 3) tick;
    end
    ready_i = 1'b1; valid_i = 1'b0; tick;
    chk("t2_produced", valid_o, 1'b0);

    // size 0 clamps to 5; words 6,7 form a new frame with length sampled at word 6
    valid_i = 1'b1; data_size_i = 3'd0;
    for (int i = 1; i <= 5; i++) begin
      data_i = 16'(i); tick;
    end
    chk("t3_valid", valid_o, 1'b1);
    chk("t3_size", data_size_o, 3'd5);
    chk("t3_data", data_o, fr(1, 2, 3, 4, 5));
    valid_i = 1'b0; tick;
    valid_i = 1'b1; data_size_i = 3'd2; data_i = 16'sd6; tick;
    data_size_i = 3'd4; data_i = 16'sd7; tick;
    chk("t3b_valid", valid_o, 1'b1);
    chk("t3b_size", data_size_o, 3'd2);
    chk("t3b_data", data_o, fr(6, 7, 0, 0, 0));
    valid_i = 1'b0; tick;

    // len 1 stream
    valid_i = 1'b1; data_size_i = 3'd1;
    for (int w = 4; w <= 6; w++) begin
      data_i = 16'(w); tick;
      chk("t4_valid", valid_o, 1'b1);
      chk("t4_size", data_size_o, 3'd1);
      chk("t4_data", data_o, fr(w, 0, 0, 0, 0));
      tick;
      chk("t4_v_drop", valid_o, 1'b0);
    end
    valid_i = 1'b0; tick;

    // async reset after 2 of 4 words
    valid_i = 1'b1; data_size_i = 3'd4;
    data_i = 16'sd11; tick;
    data_i = 16'sd12; tick;
    valid_i = 1'b0;
    chk("t5_partial", data_o, fr(11, 12, 0, 0, 0));
    #2 reset_i = 1'b1;
    #1;
    chk("t5_valid", valid_o, 1'b0);
    chk("t5_data", data_o, 80'd0);
    chk("t5_ready", ready_o, 1'b0);
    chk("t5_size", data_size_o, 3'd5);
    tick;
    reset_i = 1'b0;
    #1;
    valid_i = 1'b1; data_size_i = 3'd4;
    for (int i = 21; i <= 24; i++) begin
      data_i = 16'(i); tick;
    end
    chk("t5b_valid", valid_o, 1'b1);
    chk("t5b_size", data_size_o, 3'd4);
    chk("t5b_data", data_o, fr(21, 22, 23, 24, 0));
    valid_i = 1'b0; tick;
`else
    begin
      int  nxt;
      logic acc;
      nxt = 1;
      tick;
      data_size_i = 3'd2; valid_i = 1'b1;
      for (int c = 1; c <= 9; c++) begin
        ready_i = (c >= 7);
        data_i  = 16'(nxt);
        acc     = ready_o;
        tick;
        if (acc) nxt++;
        if (c == 2) begin
          chk("db_f1_valid", valid_o, 1'b1);
          chk("db_f1_data", data_o, fr(1, 2, 0, 0, 0));
          chk("db_f1_ready", ready_o, 1'b1);
        end
        if (c == 4 || c == 6) begin
          chk("db_full_ready", ready_o, 1'b0);
          chk("db_full_valid", valid_o, 1'b1);
          chk("db_full_data", data_o, fr(1, 2, 0, 0, 0));
        end
        if (c == 7) begin
          chk("db_f2_valid", valid_o, 1'b1);
          chk("db_f2_data", data_o, fr(3, 4, 0, 0, 0));
          chk("db_f2_size", data_size_o, 3'd2);
          chk("db_f2_ready", ready_o, 1'b1);
        end
        if (c == 8) chk("db_gap_valid", valid_o, 1'b0);
        if (c == 9) begin
          chk("db_f3_valid", valid_o, 1'b1);
          chk("db_f3_data", data_o, fr(5, 6, 0, 0, 0));
        end
      end
      chk("db_count", 80'(nxt), 80'd7);
      valid_i = 1'b0;
      tick;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_layer.md
Name: sipo_layer

Overview:
Serial-In-Parallel-Out layer that collects a variable-length stream of words into one parallel frame. It presents the complete frame as a single vector together with its word count. It is the inverse of the PISO layer and sits between a serial producer (conv/FIR output) and a parallel-consuming layer (dense/flatten). Both sides use valid-ready handshakes; the block is a helpful producer and a helpful consumer.

Parameters:
MAX_OUTPUT_SIZE, 5, maximum words per frame; sets width of data_o.
WORD_SIZE, 16, bits per word.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
reset_i  input  1  asynchronous, active-high reset.
valid_i  input  1  prev layer has a valid word.
ready_o  output  1  this layer can accept a word.
data_i  input  WORD_SIZE (signed)  serial input word.
data_size_i  input  $clog2(MAX_OUTPUT_SIZE+1)  frame length; sampled only with the first word of a frame.
valid_o  output  1  parallel frame is valid.
ready_i  input  1  next layer can accept the frame.
data_o  output  [MAX_OUTPUT_SIZE-1:0][WORD_SIZE-1:0] (signed)  parallel frame; word k of the frame is at data_o[k].
data_size_o  output  $clog2(MAX_OUTPUT_SIZE+1)  word count of the frame on data_o.

Behaviour:
- Reset (asynchronous, active-high): state=eFILL; write index=0; all data registers=0; data_size_o=MAX_OUTPUT_SIZE; valid_o=0. ready_o is 0 while reset_i is high and 1 in the first cycle after release.
- Handshakes:
  - consume = valid_i && ready_o.
  - produce = valid_o && ready_i.
  - data_o and data_size_o are held stable while valid_o=1 and no produce occurs.
- Frame length:
  - On a consume with write index 0, data_size_i is latched as the frame length.
  - A latched value of 0 or a value greater than MAX_OUTPUT_SIZE is clamped to MAX_OUTPUT_SIZE.
- Fill behaviour:
  - Each consume writes data_i into slot[index], then increments the index.
  - At the start of a frame (index 0 consume), slots 1..MAX_OUTPUT_SIZE-1 are cleared to 0, so unused slots read 0.
- State machine (base build):
  - eFILL: ready_o=1, valid_o=0. A consume with index == len-1 sets index to 0 and moves to eVALID.
  - eVALID: ready_o=0, valid_o=1. A produce moves to eFILL.
- Latency and throughput:
  - The final word is accepted in cycle N; valid_o=1 in cycle N+1.
  - Throughput is len+1 cycles per frame when ready_i is held high.
- Frame length 1: every accepted word produces a frame by itself.
- valid_i may be driven during eVALID; it is ignored because ready_o=0, and no data is lost.

Optional Feature:
Macro: SIPO_DOUBLE_BUFFER_EN
- Defined:
  - A separate fill buffer and output buffer are used, with a third state eFULL.
  - The fill buffer keeps accepting words while the output buffer is held (ready_o=1 in eVALID).
  - When a frame completes while the output is still unacknowledged, the state moves to eFULL and ready_o drops to 0.
  - A produce in eFULL copies the fill buffer to the output buffer; valid_o stays 1 and ready_o returns to 1 the next cycle.
  - Final-word consume in the same cycle as a produce: the new frame is valid the next cycle with no bubble.
  - Sustained throughput is len cycles per frame.
- Undefined: the single-buffer behaviour above. Port list and reset values are identical in both builds.

Test Plan:
- Reset then data_size_i=3, words 10,-2,7 with valid_i held high, ready_i=1 -> valid_o rises exactly 1 cycle after the 3rd consume; data_o={0,0,7,-2,10} (index 4..0), data_size_o=3; one cycle later valid_o=0 and ready_o=1.
- data_size_i=5, words 1..5, ready_i=0 for 4 cycles -> valid_o and data_o are stable for all 4 cycles; ready_o=0 throughout (base build); frame is produced on the first ready_i=1.
- data_size_i=0, then 7 words -> frame length is clamped to 5; the first frame is words 1-5; words 6-7 begin the next frame, whose length is sampled from data_size_i at word 6.
- data_size_i=1 with a continuous stream 4,5,6 and ready_i=1 -> three frames, each data_size_o=1 with data_o[0]=4, 5 and 6 respectively; other slots 0.
- reset_i asserted asynchronously mid-frame after 2 of 4 words -> valid_o=0 and data_o=0 immediately; after release a new 4-word frame is assembled correctly with no stale words.
- SIPO_DOUBLE_BUFFER_EN, len=2, valid_i always high, ready_i low for 6 cycles -> second frame fills; ready_o=0 in eFULL; on ready_i=1, frame 2 appears on the next cycle and no input word is dropped or duplicated.
